// File: rtl/accel_bin2bcd.sv
// Signed two's-complement to sign + 4-digit BCD, iterative double-dabble (one bit per clock).
// Latency W+1 cycles start-to-done; start ignored while busy; outputs held between conversions.
module accel_bin2bcd #(
    parameter int W     = 13,
    parameter bit BLANK = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] value,
    output logic         busy,
    output logic         done,
    output logic         neg,
    output logic [3:0]   bcd3,
    output logic [3:0]   bcd2,
    output logic [3:0]   bcd1,
    output logic [3:0]   bcd0
);
    localparam int            CW      = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_IT = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [W:0]    ONE_EXT = (W + 1)'(1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t        r_state, w_state_nxt;
    logic          w_load, w_last;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_bcd;
    logic [W-1:0]  r_mag;
    logic          r_sign, r_nz;
    logic [W:0]    w_sext, w_mag_full;
    logic [15:0]   w_adj, w_bcd_shift;
    logic [3:0]    w_d3, w_d2, w_d1;
    logic          r_busy, r_done, r_neg;
    logic [3:0]    r_bcd3, r_bcd2, r_bcd1, r_bcd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == LAST_IT) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Negate at W+1 bits so the most negative input yields its true magnitude.
    assign w_sext     = {value[W-1], value};
    assign w_mag_full = value[W-1] ? (~w_sext + ONE_EXT) : w_sext;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    assign w_bcd_shift = {w_adj[14:0], r_mag[W-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_mag  <= '0;
            r_sign <= 1'b0;
            r_nz   <= 1'b0;
        end else if (w_load) begin
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_mag  <= w_mag_full[W-1:0];
            r_sign <= value[W-1];
            r_nz   <= |w_mag_full;
        end else if (r_state == S_SHIFT) begin
            r_cnt  <= r_cnt + CNT_ONE;
            r_bcd  <= w_bcd_shift;
            r_mag  <= {r_mag[W-2:0], 1'b0};
        end
    end

    // Leading-zero blanking stops at the first nonzero digit; units digit always shown.
    always_comb begin
        w_d3 = w_bcd_shift[15:12];
        w_d2 = w_bcd_shift[11:8];
        w_d1 = w_bcd_shift[7:4];
        if (BLANK && (w_bcd_shift[15:12] == 4'd0)) begin
            w_d3 = 4'hF;
            if (w_bcd_shift[11:8] == 4'd0) begin
                w_d2 = 4'hF;
                if (w_bcd_shift[7:4] == 4'd0) w_d1 = 4'hF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_neg  <= 1'b0;
            r_bcd3 <= 4'hF;
            r_bcd2 <= 4'hF;
            r_bcd1 <= 4'hF;
            r_bcd0 <= 4'h0;
        end else begin
            r_busy <= (w_state_nxt == S_SHIFT);
            r_done <= w_last;
            if (w_last) begin
                r_neg  <= r_sign & r_nz;
                r_bcd3 <= w_d3;
                r_bcd2 <= w_d2;
                r_bcd1 <= w_d1;
                r_bcd0 <= w_bcd_shift[3:0];
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign neg  = r_neg;
    assign bcd3 = r_bcd3;
    assign bcd2 = r_bcd2;
    assign bcd1 = r_bcd1;
    assign bcd0 = r_bcd0;

endmodule

// File: tb/tb_accel_bin2bcd.sv
// Bench for accel_bin2bcd: blanking and non-blanking instances share stimulus and are
// checked every cycle against a countdown/arithmetic model, plus literal directed results.
module tb_accel_bin2bcd;
    localparam int W = 13;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] value = '0;

    logic       a_busy, a_done, a_neg, b_busy, b_done, b_neg;
    logic [3:0] a_bcd3, a_bcd2, a_bcd1, a_bcd0, b_bcd3, b_bcd2, b_bcd1, b_bcd0;
    logic [15:0] a_bcd, b_bcd;
    assign a_bcd = {a_bcd3, a_bcd2, a_bcd1, a_bcd0};
    assign b_bcd = {b_bcd3, b_bcd2, b_bcd1, b_bcd0};

    int checks = 0;
    int errors = 0;

    accel_bin2bcd #(.W(W), .BLANK(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(a_busy), .done(a_done), .neg(a_neg),
        .bcd3(a_bcd3), .bcd2(a_bcd2), .bcd1(a_bcd1), .bcd0(a_bcd0)
    );

    accel_bin2bcd #(.W(W), .BLANK(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(b_busy), .done(b_done), .neg(b_neg),
        .bcd3(b_bcd3), .bcd2(b_bcd2), .bcd1(b_bcd1), .bcd0(b_bcd0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a conversion is a W-cycle countdown, result is plain decimal arithmetic.
    int cd      = 0;
    int cap_v   = 0;
    int m_mag   = 0;
    bit m_neg   = 1'b0;
    bit m_valid = 1'b0;
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd = 0; m_valid = 1'b0; m_neg = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_mag = 0;
        end else begin
            m_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                    m_valid = 1'b1;
                    m_mag   = (cap_v < 0) ? -cap_v : cap_v;
                    m_neg   = (cap_v < 0);
                end
            end else if (start) begin
                cap_v  = int'($signed(value));
                cd     = W;
                m_busy = 1'b1;
            end
        end
    end

    function automatic logic [15:0] exp_digits(input bit blank);
        logic [3:0] d3, d2, d1, d0;
        if (!m_valid) return 16'hFFF0;
        d3 = 4'(m_mag / 1000);
        d2 = 4'((m_mag / 100) % 10);
        d1 = 4'((m_mag / 10) % 10);
        d0 = 4'(m_mag % 10);
        if (blank) begin
            if (m_mag < 1000) d3 = 4'hF;
            if (m_mag < 100)  d2 = 4'hF;
            if (m_mag < 10)   d1 = 4'hF;
        end
        return {d3, d2, d1, d0};
    endfunction

    always @(negedge clk) begin
        chk("a_busy", int'(a_busy), int'(m_busy));
        chk("a_done", int'(a_done), int'(m_done));
        chk("a_neg",  int'(a_neg),  int'(m_neg));
        chk("a_bcd",  int'(a_bcd),  int'(exp_digits(1'b1)));
        chk("b_busy", int'(b_busy), int'(m_busy));
        chk("b_done", int'(b_done), int'(m_done));
        chk("b_neg",  int'(b_neg),  int'(m_neg));
        chk("b_bcd",  int'(b_bcd),  int'(exp_digits(1'b0)));
    end

    // Returns at the negedge of the done cycle; glitch >= 0 pulses start=999 mid-conversion.
    task automatic run_conv(input int v, input logic [15:0] exp_a, input logic [15:0] exp_b,
                            input bit exp_neg, input bit now, input int glitch);
        int busy_cnt = 0;
        int lat = 0;
        bit found = 1'b0;
        if (!now) @(negedge clk);
        #1;
        value = W'(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            lat = i + 1;
            if (a_done) found = 1'b1;
            else if (a_busy) busy_cnt++;
            if (!found && i == glitch) begin
                #1; start = 1'b1; value = W'(999);
            end else if (!found && glitch >= 0 && i == glitch + 1) begin
                #1; start = 1'b0;
            end
        end
        chk("done_seen", int'(found), 1);
        chk("busy_cycles", busy_cnt, W);
        chk("done_latency", lat, W + 1);
        chk("lit_a_bcd", int'(a_bcd), int'(exp_a));
        chk("lit_b_bcd", int'(b_bcd), int'(exp_b));
        chk("lit_neg", int'(a_neg), int'(exp_neg));
    endtask

    initial begin
        int ndone;
        int sel;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_a_bcd", int'(a_bcd), 16'hFFF0);
        chk("rst_b_bcd", int'(b_bcd), 16'hFFF0);
        chk("rst_busy_done_neg", int'({a_busy, a_done, a_neg}), 0);

        run_conv(0,     16'hFFF0, 16'h0000, 1'b0, 1'b0, -1);
        run_conv(1234,  16'h1234, 16'h1234, 1'b0, 1'b0, -1);
        run_conv(-4096, 16'h4096, 16'h4096, 1'b1, 1'b0, -1);
        run_conv(4095,  16'h4095, 16'h4095, 1'b0, 1'b0, -1);
        run_conv(-7,    16'hFFF7, 16'h0007, 1'b1, 1'b0, -1);
        run_conv(105,   16'hF105, 16'h0105, 1'b0, 1'b0, -1);
        run_conv(321,   16'hF321, 16'h0321, 1'b0, 1'b0, 3);
        run_conv(50,    16'hFF50, 16'h0050, 1'b0, 1'b1, -1);

        // Reset in the middle of a conversion.
        @(negedge clk);
        #1 value = W'(777); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_a_bcd", int'(a_bcd), 16'hFFF0);
        chk("abort_b_bcd", int'(b_bcd), 16'hFFF0);
        chk("abort_busy_done_neg", int'({a_busy, a_done, a_neg}), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_done || b_done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_conv(42, 16'hFF42, 16'h0042, 1'b0, 1'b0, -1);

        // Random traffic, including starts during busy and on done cycles, and stray resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
            start = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 7);
            case (sel)
                0: value = W'(-4096);
                1: value = W'(4095);
                2: value = '0;
                3: value = W'(-1);
                default: value = W'($urandom);
            endcase
        end
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accel_bin2bcd.md
# accel_bin2bcd

Sequential signed-binary to BCD converter for the accelerometer display path. It takes a two's-complement axis reading from the accelerometer readout logic and produces a sign flag plus four BCD digits. Each digit feeds one 7-segment decoder instance. Conversion uses iterative double-dabble (add-3/shift, one bit per clock) with a start/busy/done handshake. Outputs stay stable between conversions, so the displays never show intermediate values.

## Interface
- W, 13: input width in bits, signed two's complement. Legal range 2..14, so |value| ≤ 8192 always fits in 4 digits.
- BLANK, 1: 1 = leading-zero blanking enabled; 0 = all four digits always numeric.

- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- value  in  W  signed sample; captured on the accepted start edge.
- busy  out  1  high while converting.
- done  out  1  one-cycle pulse when new digits are valid.
- neg  out  1  1 when the last converted value was negative.
- bcd3  out  4  thousands digit.
- bcd2  out  4  hundreds digit.
- bcd1  out  4  tens digit.
- bcd0  out  4  units digit.

## Operation
- Blank code is 4'hF. The downstream decoder maps any code above 9 to all segments off.
- States:
  - IDLE: waits for start.
  - SHIFT: W iterations of double-dabble.
  - Return to IDLE happens on the edge that ends the last SHIFT cycle. That edge also registers the outputs.
- On start in IDLE:
  - Latch sign = value[W-1].
  - Latch magnitude = sign ? -value : value, computed at W+1 bits so that the most negative input converts correctly.
  - Clear the 16-bit BCD accumulator and the iteration counter; go to SHIFT.
- Each SHIFT cycle:
  - Every BCD nibble ≥ 5 gets +3.
  - Then {bcd, mag} shifts left by 1 and the counter increments.
  - After iteration W, the state returns to IDLE.
- Output register update (only at conversion end):
  - bcd3..bcd0 take the final accumulator digits.
  - neg = sign AND (magnitude ≠ 0).
  - If BLANK = 1, each leading zero in bcd3, bcd2, bcd1 is replaced by 4'hF. Scan runs from bcd3 downward and stops at the first nonzero digit. bcd0 is never blanked.
- start while busy is ignored; it is not queued.
- Reset values: bcd3 = bcd2 = bcd1 = 4'hF, bcd0 = 4'h0 (display shows "0"), neg = 0, busy = 0, done = 0, state IDLE.
- Reset asserted mid-conversion aborts it. Outputs return to reset values immediately (asynchronously). No done is issued.

## Timing
- start = 1 at edge t (IDLE) → busy = 1 from t+1 through t+W.
- At edge t+W the final shift completes, giving these values for the cycle t+W to t+W+1:
  - outputs updated;
  - done = 1 for exactly that one cycle;
  - busy = 0;
  - state IDLE.
- Latency is W+1 cycles from the start edge to the done-high cycle. The default is 14 cycles.
- A start asserted during the done cycle is accepted, giving back-to-back conversions every W+1 cycles.
- bcd3..bcd0 and neg change only at the done edge and at reset. They hold otherwise, including throughout busy.
- done never overlaps busy.
- All outputs are registered, with no combinational path from start or value to any output.

## Test plan
- value = 0, start pulse → done at start+14 cycles; bcd3..0 = F,F,F,0; neg = 0.
- value = 1234 → bcd3..0 = 1,2,3,4; neg = 0. busy is high for exactly 13 cycles, then done is high for 1 cycle.
- value = 13'h1000 (-4096) → bcd3..0 = 4,0,9,6; neg = 1. value = 13'h0FFF (4095) → 4,0,9,5; neg = 0.
- value = -7, BLANK = 1 → F,F,F,7, neg = 1. Same input with BLANK = 0 → 0,0,0,7, neg = 1. value = 105, BLANK = 1 → F,1,0,5.
- Start 321, pulse start with value 999 during busy → result 3,2,1 with a single done. Then start 50 on the done cycle → done 14 cycles later with F,F,5,0.
- Pull rst_n low 5 cycles into a conversion → outputs immediately F,F,F,0, neg 0, busy 0, and no done follows. A subsequent start with 42 → F,F,4,2.
